// File: rtl/gate_mux.sv
// gate_mux: register-mapped pulse router steering gen_in onto one of N_CH channels.
// Supports continuous and counted-burst modes. Define GATE_MUX_SYNC_EN to add a 2-flop gen_in synchroniser.
module gate_mux #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned N_CH        = 16,
    parameter int unsigned BASE_ADDR   = 8'h20,
    parameter int unsigned BURST_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  gen_in,
    output logic [N_CH-1:0]       ch_out,
    output logic                  gen_out,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

    localparam logic [DATA_WIDTH-1:0] A_CTRL   = DATA_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] A_ERR    = DATA_WIDTH'(BASE_ADDR + 1);
    localparam logic [DATA_WIDTH-1:0] A_CH     = DATA_WIDTH'(BASE_ADDR + 2);
    localparam logic [DATA_WIDTH-1:0] A_BLO    = DATA_WIDTH'(BASE_ADDR + 3);
    localparam logic [DATA_WIDTH-1:0] A_BHI    = DATA_WIDTH'(BASE_ADDR + 4);
    localparam logic [DATA_WIDTH-1:0] A_STATUS = DATA_WIDTH'(BASE_ADDR + 5);
    localparam logic [DATA_WIDTH-1:0] N_CH_V   = DATA_WIDTH'(N_CH);

    logic                    enable_q, enable_d;
    logic                    mode_q, mode_d;
    logic [2:0]              err_q, err_d, err_set;
    logic [7:0]              ch_q, ch_d;
    logic [DATA_WIDTH-1:0]   burst_lo_q, burst_lo_d;
    logic [DATA_WIDTH-1:0]   burst_hi_q, burst_hi_d;
    logic [DATA_WIDTH-1:0]   data_out_q, rdata;
    logic [2*DATA_WIDTH-1:0] burst_full;
    logic [BURST_WIDTH-1:0]  burst_cnt;
    logic [BURST_WIDTH-1:0]  cnt_q;
    state_e                  state_q;
    logic                    open_q, done_q, gen_prev_q;
    logic                    gen_s, busy_int, soft_rst, start_req;
    logic                    wr_ctrl, wr_err, wr_ch, wr_blo, wr_bhi;

`ifdef GATE_MUX_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= gen_in;
            sync2_q <= sync1_q;
        end
    end

    assign gen_s = sync2_q;
`else
    assign gen_s = gen_in;
`endif

    assign wr_ctrl    = we && (addr == A_CTRL);
    assign wr_err     = we && (addr == A_ERR);
    assign wr_ch      = we && (addr == A_CH);
    assign wr_blo     = we && (addr == A_BLO);
    assign wr_bhi     = we && (addr == A_BHI);
    assign soft_rst   = wr_ctrl && data_in[0];
    assign busy_int   = (state_q == StArmed) || (state_q == StRun);
    assign burst_full = {burst_hi_q, burst_lo_q};
    assign burst_cnt  = burst_full[BURST_WIDTH-1:0];

    // Register file next state; rejected writes only raise sticky error bits.
    always_comb begin
        enable_d   = enable_q;
        mode_d     = mode_q;
        ch_d       = ch_q;
        burst_lo_d = burst_lo_q;
        burst_hi_d = burst_hi_q;
        err_set    = 3'b000;
        start_req  = 1'b0;

        if (wr_ctrl) begin
            enable_d = data_in[1];
            if (busy_int && (data_in[2] != mode_q)) begin
                err_set[1] = 1'b1;
            end else begin
                mode_d = data_in[2];
            end
            if (data_in[3] && mode_d && !busy_int) begin
                if (!data_in[1] || (burst_cnt == '0)) begin
                    err_set[2] = 1'b1;
                end else begin
                    start_req = 1'b1;
                end
            end
        end

        if (wr_ch) begin
            if (busy_int) begin
                err_set[1] = 1'b1;
            end else if (data_in > N_CH_V) begin
                err_set[0] = 1'b1;
            end else begin
                ch_d = data_in[7:0];
            end
        end

        if (wr_blo) begin
            if (busy_int) err_set[1] = 1'b1;
            else burst_lo_d = data_in;
        end

        if (wr_bhi) begin
            if (busy_int) err_set[1] = 1'b1;
            else burst_hi_d = data_in;
        end

        if (wr_err) err_d = (err_q & ~data_in[2:0]) | err_set;
        else err_d = err_q | err_set;

        if (soft_rst) begin
            enable_d   = 1'b0;
            mode_d     = 1'b0;
            ch_d       = '0;
            burst_lo_d = '0;
            burst_hi_d = '0;
            err_d      = '0;
            start_req  = 1'b0;
        end
    end

    always_comb begin
        case (addr)
            A_CTRL:   rdata = DATA_WIDTH'({mode_q, enable_q, 1'b0});
            A_ERR:    rdata = DATA_WIDTH'(err_q);
            A_CH:     rdata = DATA_WIDTH'(ch_q);
            A_BLO:    rdata = burst_lo_q;
            A_BHI:    rdata = burst_hi_q;
            A_STATUS: rdata = DATA_WIDTH'({done_q, busy_int});
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            enable_q   <= 1'b0;
            mode_q     <= 1'b0;
            err_q      <= '0;
            ch_q       <= '0;
            burst_lo_q <= '0;
            burst_hi_q <= '0;
            data_out_q <= '0;
        end else begin
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            ch_q       <= ch_d;
            burst_lo_q <= burst_lo_d;
            burst_hi_q <= burst_hi_d;
            data_out_q <= soft_rst ? '0 : rdata;
        end
    end

    // Burst FSM; uses next-state enable so an aborting write closes the gate at once.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            open_q     <= 1'b0;
            done_q     <= 1'b0;
            gen_prev_q <= 1'b0;
        end else begin
            gen_prev_q <= gen_s;
            if (soft_rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                open_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_req) begin
                            state_q <= StArmed;
                            done_q  <= 1'b0;
                            open_q  <= 1'b0;
                        end else begin
                            open_q <= enable_d && !mode_d && (ch_d != '0);
                        end
                    end
                    StArmed: begin
                        if (!enable_d) begin
                            state_q <= StIdle;
                            open_q  <= 1'b0;
                        end else if (!gen_s) begin
                            // Only open on a low level so no partial first pulse leaks out.
                            state_q <= StRun;
                            open_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    StRun: begin
                        if (!enable_d) begin
                            state_q <= StIdle;
                            open_q  <= 1'b0;
                        end else if (gen_prev_q && !gen_s) begin
                            if (cnt_q != burst_cnt) cnt_q <= cnt_q + BURST_WIDTH'(1);
                            if ((cnt_q + BURST_WIDTH'(1)) == burst_cnt) begin
                                state_q <= StDone;
                                open_q  <= 1'b0;
                            end
                        end
                    end
                    StDone: begin
                        open_q <= 1'b0;
                        if (start_req) begin
                            state_q <= StArmed;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        open_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_CH); k++) begin
            ch_out[k] = gen_s && open_q && (ch_q == 8'(k + 1));
        end
    end

    assign gen_out  = |ch_out;
    assign busy     = busy_int;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_gate_mux.sv
// Directed self-checking bench for gate_mux with default parameters.
module tb_gate_mux;

    localparam logic [7:0] A_CTRL   = 8'h20;
    localparam logic [7:0] A_ERR    = 8'h21;
    localparam logic [7:0] A_CH     = 8'h22;
    localparam logic [7:0] A_BLO    = 8'h23;
    localparam logic [7:0] A_BHI    = 8'h24;
    localparam logic [7:0] A_STATUS = 8'h25;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [7:0]  addr = '0;
    logic [7:0]  data_in = '0;
    logic        we = 1'b0;
    logic [7:0]  data_out;
    logic        gen_in = 1'b0;
    logic [15:0] ch_out;
    logic        gen_out;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    int ch3_rise   = 0;
    int total_rise = 0;
    int gen_rise   = 0;
    logic [15:0] ch_prev = '0;

    gate_mux dut (
        .clk      (clk),
        .res      (res),
        .addr     (addr),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out),
        .gen_in   (gen_in),
        .ch_out   (ch_out),
        .gen_out  (gen_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(ch_out) begin
        for (int k = 0; k < 16; k++) begin
            if (ch_out[k] && !ch_prev[k]) begin
                total_rise++;
                if (k == 2) ch3_rise++;
            end
        end
        ch_prev = ch_out;
    end

    always @(posedge gen_out) gen_rise++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; data_in = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        addr = a;
        @(negedge clk);
        v = data_out;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            gen_in = 1'b1;
            repeat (2) @(negedge clk);
            gen_in = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        repeat (2) @(negedge clk);
        n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h required 00", data_out); else n_pass++;
        n_checks++; if (ch_out !== 16'h0) $display("FAIL reset_ch_out: got %h required 0000", ch_out); else n_pass++;
        n_checks++; if (gen_out !== 1'b0) $display("FAIL reset_gen_out: got %b required 0", gen_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        res = 1'b0;
        @(negedge clk);
        rd(A_CH, v);
        n_checks++; if (v !== 8'h00) $display("FAIL reset_ch_reg: got %h required 00", v); else n_pass++;
    endtask

    task automatic test_continuous;
        int c3, tot, g;
        logic [7:0] v;
        wr(A_CH, 8'h03);
        wr(A_CTRL, 8'h02);
        rd(A_CTRL, v);
        n_checks++; if (v !== 8'h02) $display("FAIL cont_ctrl_read: got %h required 02", v); else n_pass++;
        c3 = ch3_rise; tot = total_rise; g = gen_rise;
        pulses(5);
        n_checks++; if (ch3_rise - c3 !== 5) $display("FAIL cont_ch3_pulses: got %0d required 5", ch3_rise - c3); else n_pass++;
        n_checks++; if (gen_rise - g !== 5) $display("FAIL cont_gen_pulses: got %0d required 5", gen_rise - g); else n_pass++;
        n_checks++; if (total_rise - tot !== 5) $display("FAIL cont_other_bits: got %0d total rises required 5", total_rise - tot); else n_pass++;
        wr(A_CTRL, 8'h00);
    endtask

    task automatic test_ch_range;
        logic [7:0] v;
        wr(A_CH, 8'd17);
        rd(A_ERR, v);
        n_checks++; if (v !== 8'h01) $display("FAIL range_err: got %h required 01", v); else n_pass++;
        rd(A_CH, v);
        n_checks++; if (v !== 8'h03) $display("FAIL range_ch_kept: got %h required 03", v); else n_pass++;
        wr(A_ERR, 8'h01);
        rd(A_ERR, v);
        n_checks++; if (v !== 8'h00) $display("FAIL range_err_clear: got %h required 00", v); else n_pass++;
    endtask

    task automatic test_burst;
        int c3, tot, g;
        logic [7:0] v;
        wr(A_BLO, 8'h03);
        wr(A_BHI, 8'h00);
        gen_in = 1'b1;
        @(negedge clk);
        c3 = ch3_rise; tot = total_rise; g = gen_rise;
        wr(A_CTRL, 8'h0E);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL burst_armed_busy: got %b required 1", busy); else n_pass++;
        n_checks++; if (ch_out !== 16'h0) $display("FAIL burst_armed_closed: got %h required 0000", ch_out); else n_pass++;
        gen_in = 1'b0;
        repeat (2) @(negedge clk);
        pulses(5);
        n_checks++; if (ch3_rise - c3 !== 3) $display("FAIL burst_ch3_pulses: got %0d required 3", ch3_rise - c3); else n_pass++;
        n_checks++; if (gen_rise - g !== 3) $display("FAIL burst_gen_pulses: got %0d required 3", gen_rise - g); else n_pass++;
        n_checks++; if (total_rise - tot !== 3) $display("FAIL burst_other_bits: got %0d required 3", total_rise - tot); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL burst_busy_after: got %b required 0", busy); else n_pass++;
        rd(A_STATUS, v);
        n_checks++; if (v !== 8'h02) $display("FAIL burst_status: got %h required 02", v); else n_pass++;
    endtask

    task automatic test_busy_reject;
        int c3, tot;
        logic [7:0] v;
        wr(A_BLO, 8'h02);
        wr(A_CTRL, 8'h0E);
        @(negedge clk);
        wr(A_CH, 8'h05);
        rd(A_ERR, v);
        n_checks++; if (v !== 8'h02) $display("FAIL busy_ch_err: got %h required 02", v); else n_pass++;
        rd(A_CH, v);
        n_checks++; if (v !== 8'h03) $display("FAIL busy_ch_kept: got %h required 03", v); else n_pass++;
        c3 = ch3_rise; tot = total_rise;
        pulses(3);
        n_checks++; if (ch3_rise - c3 !== 2) $display("FAIL busy_burst_pulses: got %0d required 2", ch3_rise - c3); else n_pass++;
        n_checks++; if (total_rise - tot !== 2) $display("FAIL busy_other_bits: got %0d required 2", total_rise - tot); else n_pass++;
        rd(A_STATUS, v);
        n_checks++; if (v !== 8'h02) $display("FAIL busy_status: got %h required 02", v); else n_pass++;
        wr(A_ERR, 8'h02);
        wr(A_BLO, 8'h00);
        wr(A_CTRL, 8'h0E);
        rd(A_ERR, v);
        n_checks++; if (v !== 8'h04) $display("FAIL zero_start_err: got %h required 04", v); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_start_idle: got %b required 0", busy); else n_pass++;
        wr(A_ERR, 8'h04);
        wr(A_BLO, 8'h02);
        wr(A_CTRL, 8'h0C);
        rd(A_ERR, v);
        n_checks++; if (v !== 8'h04) $display("FAIL disabled_start_err: got %h required 04", v); else n_pass++;
        wr(A_ERR, 8'h04);
        rd(A_ERR, v);
        n_checks++; if (v !== 8'h00) $display("FAIL err_w1c: got %h required 00", v); else n_pass++;
    endtask

    task automatic test_abort;
        logic [7:0] v;
        wr(A_BLO, 8'h03);
        wr(A_CTRL, 8'h0E);
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_running: got %b required 1", busy); else n_pass++;
        wr(A_CTRL, 8'h04);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy); else n_pass++;
        rd(A_STATUS, v);
        n_checks++; if (v !== 8'h00) $display("FAIL abort_status: got %h required 00", v); else n_pass++;
        rd(A_ERR, v);
        n_checks++; if (v !== 8'h00) $display("FAIL abort_err: got %h required 00", v); else n_pass++;
    endtask

    task automatic test_soft_reset;
        logic [7:0] v;
        wr(A_BLO, 8'h07);
        wr(A_BHI, 8'h01);
        wr(A_CH, 8'd20);
        wr(A_CTRL, 8'h02);
        gen_in = 1'b1;
        #1;
        n_checks++; if (ch_out !== 16'h0004) $display("FAIL soft_pre_open: got %h required 0004", ch_out); else n_pass++;
        wr(A_CTRL, 8'h03);
        n_checks++; if (ch_out !== 16'h0) $display("FAIL soft_closed: got %h required 0000", ch_out); else n_pass++;
        gen_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(A_CTRL + 8'(i), v);
            n_checks++; if (v !== 8'h00) $display("FAIL soft_reg_%0d: got %h required 00", i, v); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] v;
        wr(A_CH, 8'h03);
        wr(A_BLO, 8'h04);
        wr(A_CTRL, 8'h0E);
        repeat (2) @(negedge clk);
        gen_in = 1'b1;
        @(negedge clk);
        n_checks++; if (ch_out !== 16'h0004) $display("FAIL run_open: got %h required 0004", ch_out); else n_pass++;
        #2 res = 1'b1;
        #1;
        n_checks++; if (ch_out !== 16'h0) $display("FAIL async_ch_out: got %h required 0000", ch_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL async_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (gen_out !== 1'b0) $display("FAIL async_gen_out: got %b required 0", gen_out); else n_pass++;
        @(negedge clk);
        res = 1'b0;
        gen_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(A_CTRL + 8'(i), v);
            n_checks++; if (v !== 8'h00) $display("FAIL hard_reg_%0d: got %h required 00", i, v); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_continuous;
        test_ch_range;
        test_burst;
        test_busy_reject;
        test_abort;
        test_soft_reset;
        test_reset_mid_run;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_mux.md
# gate_mux

Register-mapped pulse router: steers the generator pulse train `gen_in` onto one of `N_CH` channel outputs, plus a common monitor output. It extends the single-channel gate with parametrised channel count, a counted burst mode driven by a small state machine, status readback and sticky error flags. It sits on the shared 8-bit control bus next to the other function blocks and feeds the PMT channel drivers.

## Interface
- `DATA_WIDTH`, 8: bus data width; must be ≥ 8.
- `N_CH`, 16: number of channel outputs, 1..255.
- `BASE_ADDR`, 8'h20: address of register 0; block decodes `BASE_ADDR`..`BASE_ADDR+5`.
- `BURST_WIDTH`, 16: burst counter width; must be ≤ 2·`DATA_WIDTH`.
- `clk`  in  1  sole clock; all state on rising edge.
- `res`  in  1  reset, asynchronous, active-high.
- `addr`  in  DATA_WIDTH  register address.
- `data_in`  in  DATA_WIDTH  write data.
- `we`  in  1  write strobe, one write per cycle it is high.
- `data_out`  out  DATA_WIDTH  registered read data.
- `gen_in`  in  1  pulse train from generator.
- `ch_out`  out  N_CH  gated pulse per channel; bit k serves channel k+1.
- `gen_out`  out  1  OR of all `ch_out` bits (monitor).
- `busy`  out  1  high in ARMED or RUN.

## Operation
- Registers (offset from `BASE_ADDR`): +0 CTRL, +1 ERR, +2 CH, +3 BURST_LO, +4 BURST_HI, +5 STATUS (read-only).
- CTRL: bit0 soft reset (self-clearing), bit1 enable, bit2 mode (0 continuous, 1 burst), bit3 start (self-clearing, reads 0).
- ERR (sticky, write-1-to-clear): bit0 CH write > `N_CH` rejected; bit1 CH/BURST/mode write while `busy` rejected; bit2 start with burst count 0 or enable=0 ignored.
- CH: 0 = no channel; 1..`N_CH` selects `ch_out[CH-1]`. Rejected writes leave CH unchanged.
- BURST = {BURST_HI, BURST_LO} truncated to `BURST_WIDTH`; STATUS: bit0 busy, bit1 done (sticky until next start or reset), bits[7:2] 0.
- Reads of unmapped addresses return 0.
- Gating: `ch_out[CH-1] = gen_in & open`, all other bits 0; `open` is a registered flag, gating itself is combinational so pulse edges carry no clock latency.
- Continuous mode: `open = enable & (CH != 0)`; FSM stays IDLE; start ignored without error.
- Burst FSM: IDLE → (start, burst mode, enable, count≠0) → ARMED. ARMED → RUN when sampled `gen_in` = 0 (no partial first pulse). RUN: `open`=1, count falling edges of sampled `gen_in`; on the Nth falling edge → DONE with `open`=0 at that same clock edge. DONE → IDLE next cycle, sets STATUS.done.
- Clearing enable in ARMED/RUN aborts to IDLE, `open`=0, done not set.
- Soft reset or `res`: all registers 0, FSM IDLE, `open`=0. Soft reset wins over a simultaneous write in the same cycle.

## Timing
- Reset values: `data_out`=0, `ch_out`=0, `gen_out`=0, `busy`=0.
- Write takes effect the cycle after the `we` edge; read data valid one cycle after `addr` presented.
- `open` changes one cycle after the enabling write (continuous) or one cycle after entering RUN.
- Edge detection uses `gen_in` sampled once per `clk`; pulses shorter than one `clk` high or low are not counted (requirement: generator high/low ≥ 2 clk).
- Burst of N: exactly N complete pulses appear on the selected channel; `busy` falls the cycle after the Nth falling edge is sampled.
- Counter saturates internally; no wrap past N.

## Configuration
- `GATE_MUX_SYNC_EN`: defined → `gen_in` passes a 2-flop synchroniser before edge detection and gating; outputs lag `gen_in` by 2 clk, pulse widths preserved to ±1 clk. Undefined → `gen_in` is treated as synchronous to `clk`, gating is combinational with zero latency.

## Test plan
- `res` pulse mid-RUN → `ch_out`=0, `busy`=0 asynchronously; all registers read 0.
- Write CH=3, CTRL=8'h02, toggle `gen_in` 5 times → exactly 5 pulses on `ch_out[2]` and `gen_out`, no other bit toggles.
- Write CH=`N_CH`+1 → ERR reads 8'h01, CH keeps prior value; write ERR=8'h01 → ERR reads 0.
- BURST=3, CTRL=8'h0E while `gen_in` high → wait for low, then exactly 3 pulses on selected channel; STATUS reads 8'h02 afterwards.
- Write CH during RUN → ERR bit1 set, CH unchanged, burst completes normally; start with BURST=0 → ERR bit2, FSM stays IDLE.
- CTRL=8'h01 together with any write in the same cycle → all registers 0 next cycle.
